// File: rtl/control_pipe.sv
// control_pipe: registered main-control unit for the five-stage RISC-V core.
// Decodes the D-stage instruction and carries its control fields through the
// ID/EX, EX/MEM and MEM/WB control registers. It also counts illegal
// instructions that enter E, and the count saturates at its maximum.
module control_pipe #(
  parameter int EXT_BRANCH = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instrD,
  input  logic             validD,
  input  logic             stallE,
  input  logic             flushE,
  output logic [2:0]       immSrcD,
  output logic             regWriteE,
  output logic             memWriteE,
  output logic             ALUSrcE,
  output logic             illegalE,
  output logic [1:0]       resultSrcE,
  output logic [1:0]       jumpE,
  output logic [1:0]       ALUOpE,
  output logic [2:0]       branchE,
  output logic [2:0]       func3E,
  output logic             regWriteM,
  output logic             memWriteM,
  output logic [1:0]       resultSrcM,
  output logic             regWriteW,
  output logic [1:0]       resultSrcW,
  output logic [CNT_W-1:0] illegalCount
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [6:0] op;
  logic [2:0] func3;

  logic       decRegWrite;
  logic       decMemWrite;
  logic       decALUSrc;
  logic       decIllegal;
  logic [1:0] decResultSrc;
  logic [1:0] decJump;
  logic [1:0] decALUOp;
  logic [2:0] decBranch;
  logic [2:0] decImmSrc;
  logic [2:0] brCode;

  // Register and immediate fields are not control inputs; fold them away.
  logic unusedInstrBits;

  assign op              = instrD[6:0];
  assign func3           = instrD[14:12];
  assign unusedInstrBits = ^{instrD[31:15], instrD[11:7]};

  // Map B-type func3 to a branch code; zero means the condition is not decodable.
  always_comb begin
    brCode = 3'b000;
    case (func3)
      3'b000:  brCode = 3'b001;
      3'b001:  brCode = 3'b010;
      3'b100:  brCode = 3'b011;
      3'b101:  brCode = 3'b100;
      3'b110:  brCode = (EXT_BRANCH != 0) ? 3'b101 : 3'b000;
      3'b111:  brCode = (EXT_BRANCH != 0) ? 3'b110 : 3'b000;
      default: brCode = 3'b000;
    endcase
  end

  // Main decoder: every field defaults to 0, so bubbles and illegal ops carry nothing.
  always_comb begin
    decRegWrite  = 1'b0;
    decMemWrite  = 1'b0;
    decALUSrc    = 1'b0;
    decIllegal   = 1'b0;
    decResultSrc = 2'b00;
    decJump      = 2'b00;
    decALUOp     = 2'b00;
    decBranch    = 3'b000;
    decImmSrc    = 3'b000;
    if (validD) begin
      case (op)
        OP_R: begin
          decALUOp    = 2'b10;
          decRegWrite = 1'b1;
        end
        OP_I: begin
          decALUOp    = 2'b11;
          decRegWrite = 1'b1;
          decALUSrc   = 1'b1;
        end
        OP_LW: begin
          decRegWrite  = 1'b1;
          decALUSrc    = 1'b1;
          decResultSrc = 2'b01;
        end
        OP_S: begin
          decMemWrite = 1'b1;
          decALUSrc   = 1'b1;
          decImmSrc   = 3'b001;
        end
        OP_B: begin
          if (brCode == 3'b000) begin
            decIllegal = 1'b1;
          end else begin
            decALUOp  = 2'b01;
            decImmSrc = 3'b010;
            decBranch = brCode;
          end
        end
        OP_LUI: begin
          decRegWrite  = 1'b1;
          decResultSrc = 2'b11;
          decImmSrc    = 3'b100;
        end
        OP_JAL: begin
          decRegWrite  = 1'b1;
          decResultSrc = 2'b10;
          decJump      = 2'b01;
          decImmSrc    = 3'b011;
        end
        OP_JALR: begin
          decRegWrite  = 1'b1;
          decALUSrc    = 1'b1;
          decResultSrc = 2'b10;
          decJump      = 2'b10;
        end
        default: decIllegal = 1'b1;
      endcase
    end
  end

  assign immSrcD = decImmSrc;

  // ID/EX register: reset beats flush, flush beats stall, stall holds.
  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      regWriteE  <= 1'b0;
      memWriteE  <= 1'b0;
      ALUSrcE    <= 1'b0;
      illegalE   <= 1'b0;
      resultSrcE <= 2'b00;
      jumpE      <= 2'b00;
      ALUOpE     <= 2'b00;
      branchE    <= 3'b000;
      func3E     <= 3'b000;
    end else if (!stallE) begin
      regWriteE  <= decRegWrite;
      memWriteE  <= decMemWrite;
      ALUSrcE    <= decALUSrc;
      illegalE   <= decIllegal;
      resultSrcE <= decResultSrc;
      jumpE      <= decJump;
      ALUOpE     <= decALUOp;
      branchE    <= decBranch;
      func3E     <= validD ? func3 : 3'b000;
    end
  end

  // EX/MEM register: a held E stage sends a bubble downstream.
  always_ff @(posedge clk) begin
    if (rst || (stallE && !flushE)) begin
      regWriteM  <= 1'b0;
      memWriteM  <= 1'b0;
      resultSrcM <= 2'b00;
    end else begin
      regWriteM  <= regWriteE;
      memWriteM  <= memWriteE;
      resultSrcM <= resultSrcE;
    end
  end

  // MEM/WB register: always follows M.
  always_ff @(posedge clk) begin
    if (rst) begin
      regWriteW  <= 1'b0;
      resultSrcW <= 2'b00;
    end else begin
      regWriteW  <= regWriteM;
      resultSrcW <= resultSrcM;
    end
  end

  // Count illegal instructions that actually load into E, saturating at max.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegalCount <= '0;
    end else if (decIllegal && !flushE && !stallE && (illegalCount != CNT_MAX)) begin
      illegalCount <= illegalCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: drives three control_pipe variants (default, no unsigned
// branches, 2-bit counter) with one directed stream and checks them against a
// stage-level model every cycle, plus hand-computed spot values.
module tb_control_pipe;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       aluSrc;
    logic       illegal;
    logic [1:0] resultSrc;
    logic [1:0] jump;
    logic [1:0] aluOp;
    logic [2:0] branch;
    logic [2:0] func3;
    logic [2:0] imm;
  } ctrlT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instrD = 32'h0;
  logic        validD = 1'b0;
  logic        stallE = 1'b0;
  logic        flushE = 1'b0;

  ctrlT        obsE[3];
  logic [2:0]  obsImm[3];
  logic        obsRegM[3];
  logic        obsMemM[3];
  logic [1:0]  obsResM[3];
  logic        obsRegW[3];
  logic [1:0]  obsResW[3];
  logic [31:0] obsCnt[3];

  int checks = 0;
  int failures = 0;
  bit checking = 0;

  ctrlT        mE[3];
  ctrlT        mM[3];
  ctrlT        mW[3];
  int unsigned mCnt[3];
  int          extCfg[3] = '{1, 0, 1};
  int unsigned maxCfg[3] = '{255, 255, 3};

  always #5 clk = ~clk;

  // Three variants share the stimulus; only their parameters differ.
  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int CW = (g == 2) ? 2 : 8;
    localparam int EB = (g == 1) ? 0 : 1;
    logic          regWriteE, memWriteE, ALUSrcE, illegalE;
    logic [1:0]    resultSrcE, jumpE, ALUOpE;
    logic [2:0]    branchE, func3E, immSrcD;
    logic          regWriteM, memWriteM, regWriteW;
    logic [1:0]    resultSrcM, resultSrcW;
    logic [CW-1:0] illegalCount;

    control_pipe #(.EXT_BRANCH(EB), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .instrD(instrD), .validD(validD),
      .stallE(stallE), .flushE(flushE), .immSrcD(immSrcD),
      .regWriteE(regWriteE), .memWriteE(memWriteE), .ALUSrcE(ALUSrcE),
      .illegalE(illegalE), .resultSrcE(resultSrcE), .jumpE(jumpE),
      .ALUOpE(ALUOpE), .branchE(branchE), .func3E(func3E),
      .regWriteM(regWriteM), .memWriteM(memWriteM), .resultSrcM(resultSrcM),
      .regWriteW(regWriteW), .resultSrcW(resultSrcW),
      .illegalCount(illegalCount)
    );

    assign obsE[g]    = {regWriteE, memWriteE, ALUSrcE, illegalE, resultSrcE,
                         jumpE, ALUOpE, branchE, func3E, 3'b000};
    assign obsImm[g]  = immSrcD;
    assign obsRegM[g] = regWriteM;
    assign obsMemM[g] = memWriteM;
    assign obsResM[g] = resultSrcM;
    assign obsRegW[g] = regWriteW;
    assign obsResW[g] = resultSrcW;
    assign obsCnt[g]  = 32'(illegalCount);
  end

  // Decode table straight from the opcode list.
  function automatic ctrlT modelDecode(input logic [31:0] ins, input logic v, input int ext);
    ctrlT c;
    c = '0;
    if (!v) return c;
    c.func3 = ins[14:12];
    case (ins[6:0])
      7'b0110011: begin c.aluOp = 2'b10; c.regWrite = 1; end
      7'b0010011: begin c.aluOp = 2'b11; c.regWrite = 1; c.aluSrc = 1; end
      7'b0000011: begin c.regWrite = 1; c.aluSrc = 1; c.resultSrc = 2'b01; end
      7'b0100011: begin c.memWrite = 1; c.aluSrc = 1; c.imm = 3'b001; end
      7'b0110111: begin c.regWrite = 1; c.resultSrc = 2'b11; c.imm = 3'b100; end
      7'b1101111: begin c.regWrite = 1; c.resultSrc = 2'b10; c.jump = 2'b01; c.imm = 3'b011; end
      7'b1100111: begin c.regWrite = 1; c.aluSrc = 1; c.resultSrc = 2'b10; c.jump = 2'b10; end
      7'b1100011: begin
        case (ins[14:12])
          3'b000: c.branch = 3'd1;
          3'b001: c.branch = 3'd2;
          3'b100: c.branch = 3'd3;
          3'b101: c.branch = 3'd4;
          3'b110: c.branch = (ext != 0) ? 3'd5 : 3'd0;
          3'b111: c.branch = (ext != 0) ? 3'd6 : 3'd0;
          default: c.branch = 3'd0;
        endcase
        if (c.branch == 3'd0) c.illegal = 1;
        else begin c.aluOp = 2'b01; c.imm = 3'b010; end
      end
      default: c.illegal = 1;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {7'h15, 5'd3, 5'd2, f3, 5'd1, op};
  endfunction

  task automatic checkOutput(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s inst%0d: got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic v, input logic st,
                               input logic fl, input logic r);
    @(negedge clk);
    instrD = ins; validD = v; stallE = st; flushE = fl; rst = r;
    @(posedge clk);
    #2;
  endtask

  // Advance the stage model on each edge, then compare every variant against it.
  always @(posedge clk) begin
    ctrlT d;
    ctrlT dImm [3];
    for (int k = 0; k < 3; k++) begin
      d = modelDecode(instrD, validD, extCfg[k]);
      dImm[k] = d;
      d.imm = '0;
      if (rst) begin
        mE[k] = '0; mM[k] = '0; mW[k] = '0; mCnt[k] = 0;
      end else begin
        if (d.illegal && !flushE && !stallE && mCnt[k] < maxCfg[k]) mCnt[k]++;
        mW[k] = mM[k];
        mM[k] = (stallE && !flushE) ? '0 : mE[k];
        if (flushE) mE[k] = '0;
        else if (!stallE) mE[k] = d;
      end
    end
    if (rst) checking = 1;
    #1;
    if (checking) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput("E ctrl", k, {13'b0, obsE[k]}, {13'b0, mE[k]});
        checkOutput("immSrcD", k, 32'(obsImm[k]), 32'(modelDecode(instrD, validD, extCfg[k]).imm));
        checkOutput("M ctrl", k, {28'b0, obsRegM[k], obsMemM[k], obsResM[k]},
                    {28'b0, mM[k].regWrite, mM[k].memWrite, mM[k].resultSrc});
        checkOutput("W ctrl", k, {29'b0, obsRegW[k], obsResW[k]},
                    {29'b0, mW[k].regWrite, mW[k].resultSrc});
        checkOutput("illegalCount", k, obsCnt[k], mCnt[k]);
      end
    end
  end

  initial begin
    logic [31:0] prevCnt;
    logic [31:0] ops[8];
    ops = '{mk(7'b0110011, 3'b000), mk(7'b0010011, 3'b000), mk(7'b0000011, 3'b010),
            mk(7'b0100011, 3'b010), mk(7'b1100011, 3'b000), mk(7'b0110111, 3'b000),
            mk(7'b1101111, 3'b000), mk(7'b1100111, 3'b000)};

    $display("[TB] start");
    applyStimulus(32'h0, 0, 0, 0, 1);
    applyStimulus(32'h0, 0, 0, 0, 1);
    checkOutput("reset E", 0, {13'b0, obsE[0]}, 32'h0);
    checkOutput("reset count", 0, obsCnt[0], 32'h0);

    // Every opcode once, back to back.
    foreach (ops[i]) applyStimulus(ops[i], 1, 0, 0, 0);
    checkOutput("JALR jumpE", 0, 32'(obsE[0].jump), 32'h2);

    // Branch conditions.
    applyStimulus(mk(7'b1100011, 3'b001), 1, 0, 0, 0);
    applyStimulus(mk(7'b1100011, 3'b100), 1, 0, 0, 0);
    applyStimulus(mk(7'b1100011, 3'b101), 1, 0, 0, 0);
    checkOutput("BGE branchE", 0, 32'(obsE[0].branch), 32'h4);
    prevCnt = obsCnt[1];
    applyStimulus(mk(7'b1100011, 3'b110), 1, 0, 0, 0);
    checkOutput("BLTU branchE", 0, 32'(obsE[0].branch), 32'h5);
    checkOutput("BLTU ext0 branchE", 1, 32'(obsE[1].branch), 32'h0);
    checkOutput("BLTU ext0 illegalE", 1, 32'(obsE[1].illegal), 32'h1);
    checkOutput("BLTU ext0 count", 1, obsCnt[1], prevCnt + 1);
    applyStimulus(mk(7'b1100011, 3'b111), 1, 0, 0, 0);
    checkOutput("BGEU branchE", 0, 32'(obsE[0].branch), 32'h6);
    applyStimulus(mk(7'b1100011, 3'b010), 1, 0, 0, 0);
    applyStimulus(mk(7'b0110011, 3'b000), 0, 0, 0, 0);

    // Load followed by a two-cycle stall.
    applyStimulus(ops[2], 1, 0, 0, 0);
    checkOutput("LW resultSrcE", 0, 32'(obsE[0].resultSrc), 32'h1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(ops[0], 1, 1, 0, 0);
      checkOutput("stall resultSrcE", 0, 32'(obsE[0].resultSrc), 32'h1);
      checkOutput("stall regWriteM", 0, 32'(obsRegM[0]), 32'h0);
    end
    applyStimulus(ops[0], 1, 0, 0, 0);
    checkOutput("release resultSrcM", 0, 32'(obsResM[0]), 32'h1);

    // Illegal opcode under flush+stall, then unflushed.
    prevCnt = obsCnt[0];
    applyStimulus(mk(7'b1111111, 3'b000), 1, 1, 1, 0);
    checkOutput("flushed illegalE", 0, 32'(obsE[0].illegal), 32'h0);
    checkOutput("flushed count", 0, obsCnt[0], prevCnt);
    applyStimulus(mk(7'b1111111, 3'b000), 1, 0, 0, 0);
    checkOutput("illegal illegalE", 0, 32'(obsE[0].illegal), 32'h1);
    checkOutput("illegal count", 0, obsCnt[0], prevCnt + 1);

    // Reset while JAL is in E and S is in M.
    applyStimulus(ops[3], 1, 0, 0, 0);
    applyStimulus(ops[6], 1, 0, 0, 0);
    applyStimulus(ops[0], 1, 0, 0, 1);
    checkOutput("midreset E", 0, {13'b0, obsE[0]}, 32'h0);
    checkOutput("midreset M", 0, {29'b0, obsRegM[0], obsMemM[0], obsResM[0]}, 32'h0);
    checkOutput("midreset W", 0, {29'b0, obsRegW[0], obsResW[0]}, 32'h0);
    checkOutput("midreset count", 0, obsCnt[0], 32'h0);
    applyStimulus(ops[1], 1, 0, 0, 0);
    checkOutput("after reset ALUOpE", 0, 32'(obsE[0].aluOp), 32'h3);
    for (int i = 0; i < 3; i++) applyStimulus(32'h0, 0, 0, 0, 0);

    // Saturation of the 2-bit counter: 1,2,3,3,3.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(mk(7'b1111111, 3'b000), 1, 0, 0, 0);
      checkOutput("sat count", 2, obsCnt[2], (i < 3) ? i + 1 : 3);
      checkOutput("sat illegalE", 2, 32'(obsE[2].illegal), 32'h1);
      checkOutput("wide count", 0, obsCnt[0], i + 1);
    end
    for (int i = 0; i < 3; i++) applyStimulus(32'h0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
